// File: rtl/fft32_pkg.sv
// Shared types and constants for the 32-point FFT sequencer.
package fft32_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_S0_START = 4'd2,
    ST_S0_WAIT  = 4'd3,
    ST_S0_RUN   = 4'd4,
    ST_S0_FLUSH = 4'd5,
    ST_S1_START = 4'd6,
    ST_S1_WAIT  = 4'd7,
    ST_S1_RUN   = 4'd8,
    ST_S1_FLUSH = 4'd9,
    ST_UNLOAD   = 4'd10
  } state_t;

  localparam int BEATS   = 8;
  localparam int LANES   = 4;
  localparam int RUN_CYC = 32;

  localparam logic BANK_IN  = 1'b0;
  localparam logic BANK_MID = 1'b1;

  // Stage 0 writes its results to the middle bank, stage 1 back to the input bank.
  function automatic logic wb_bank(input logic stage);
    return stage ? BANK_IN : BANK_MID;
  endfunction

endpackage

// File: rtl/fft_dly.sv
// Fixed-depth shift register used to align control with the butterfly pipeline.
module fft_dly #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe_r [D];

  // Shift the control word one stage per cycle; clr empties the whole line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < D; i++) pipe_r[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < D; i++) pipe_r[i] <= '0;
    end else begin
      pipe_r[0] <= din;
      for (int i = 1; i < D; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign dout = pipe_r[D-1];

endmodule

// File: rtl/fft32_seq.sv
// Control sequencer for the 32-point FFT: load, two butterfly stages, unload.
module fft32_seq
  import fft32_pkg::*;
#(
  parameter int ROM_LAT = 2,
  parameter int BF_LAT  = 3,
  parameter int AW      = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SOFT_CLR,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          ROM_START,
  output logic          ROM_STAGE,
  output logic          BF_EN,
  output logic [1:0]    PHASE,
  output logic [AW-1:0] BUF_RD_ADDR,
  output logic          BUF_RD_BANK,
  output logic          BUF_WE,
  output logic [AW-1:0] BUF_WR_ADDR,
  output logic          BUF_WR_BANK,
  output logic          BUSY,
  output logic          DONE,
  output logic [7:0]    FRAME_CNT
);

  localparam int              DW         = 1 + 2 + AW;
  localparam logic [4:0]      WAIT_LAST  = 5'(ROM_LAT - 1);
  localparam logic [4:0]      RUN_LAST   = 5'(RUN_CYC - 1);
  localparam logic [4:0]      FLUSH_LAST = 5'(BF_LAT - 1);
  localparam logic [AW-1:0]   BEAT_LAST  = AW'(BEATS - 1);
  localparam logic [AW-1:0]   ONE_A      = AW'(1'b1);

  state_t        state_r;
  logic [4:0]    cnt_r;
  logic [AW-1:0] beat_r;
  logic [AW-1:0] out_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          rom_start_r;
  logic          rom_stage_r;
  logic          bf_en_r;
  logic [1:0]    phase_r;
  logic [AW-1:0] rd_addr_r;
  logic          rd_bank_r;
  logic          busy_r;
  logic [7:0]    frame_cnt_r;

  logic          accept_s;
  logic          out_acc_s;
  logic [4:0]    cnt_nxt_s;
  logic [DW-1:0] dly_s;
  logic          wb_en_s;
  logic [1:0]    wb_phase_s;
  logic [AW-1:0] wb_addr_s;

  // A clear in the same cycle always wins over a handshake.
  assign accept_s  = IN_VALID & in_ready_r & ~SOFT_CLR;
  assign out_acc_s = out_valid_r & OUT_READY & ~SOFT_CLR;
  assign cnt_nxt_s = cnt_r + 5'd1;

  // Butterfly results become writable BF_LAT cycles after their operands were read.
  fft_dly #(.W(DW), .D(BF_LAT)) u_dly (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (SOFT_CLR),
    .din  ({bf_en_r, phase_r, rd_addr_r}),
    .dout (dly_s)
  );

  assign {wb_en_s, wb_phase_s, wb_addr_s} = dly_s;

  // Buffer write port: input beats during load, last sub-beat of each word during write-back.
  always_comb begin
    BUF_WE      = 1'b0;
    BUF_WR_ADDR = '0;
    BUF_WR_BANK = BANK_IN;
    if (accept_s) begin
      BUF_WE      = 1'b1;
      BUF_WR_ADDR = beat_r;
      BUF_WR_BANK = BANK_IN;
    end else if (wb_en_s && (wb_phase_s == 2'd3)) begin
      BUF_WE      = 1'b1;
      BUF_WR_ADDR = wb_addr_s;
      BUF_WR_BANK = wb_bank(rom_stage_r);
    end else begin
      BUF_WE      = 1'b0;
    end
  end

  // Main sequencer: state, counters and registered control outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      beat_r      <= '0;
      out_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      rom_start_r <= 1'b0;
      rom_stage_r <= 1'b0;
      bf_en_r     <= 1'b0;
      phase_r     <= 2'd0;
      rd_addr_r   <= '0;
      rd_bank_r   <= BANK_IN;
      busy_r      <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else if (SOFT_CLR) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      beat_r      <= '0;
      out_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      rom_start_r <= 1'b0;
      rom_stage_r <= 1'b0;
      bf_en_r     <= 1'b0;
      phase_r     <= 2'd0;
      rd_addr_r   <= '0;
      rd_bank_r   <= BANK_IN;
      busy_r      <= 1'b0;
    end else begin
      rom_start_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_LOAD: begin
          if (accept_s) begin
            busy_r <= 1'b1;
            if (beat_r == BEAT_LAST) begin
              state_r     <= ST_S0_START;
              beat_r      <= '0;
              in_ready_r  <= 1'b0;
              rom_start_r <= 1'b1;
              rom_stage_r <= 1'b0;
              rd_bank_r   <= BANK_IN;
            end else begin
              state_r <= ST_LOAD;
              beat_r  <= beat_r + ONE_A;
            end
          end
        end
        ST_S0_START, ST_S1_START: begin
          state_r <= rom_stage_r ? ST_S1_WAIT : ST_S0_WAIT;
          cnt_r   <= 5'd0;
        end
        ST_S0_WAIT, ST_S1_WAIT: begin
          if (cnt_r == WAIT_LAST) begin
            state_r   <= rom_stage_r ? ST_S1_RUN : ST_S0_RUN;
            cnt_r     <= 5'd0;
            bf_en_r   <= 1'b1;
            phase_r   <= 2'd0;
            rd_addr_r <= '0;
          end else begin
            cnt_r <= cnt_nxt_s;
          end
        end
        ST_S0_RUN, ST_S1_RUN: begin
          if (cnt_r == RUN_LAST) begin
            state_r   <= rom_stage_r ? ST_S1_FLUSH : ST_S0_FLUSH;
            cnt_r     <= 5'd0;
            bf_en_r   <= 1'b0;
            phase_r   <= 2'd0;
            rd_addr_r <= '0;
          end else begin
            cnt_r     <= cnt_nxt_s;
            phase_r   <= cnt_nxt_s[1:0];
            rd_addr_r <= AW'(cnt_nxt_s[4:2]);
          end
        end
        ST_S0_FLUSH, ST_S1_FLUSH: begin
          if (cnt_r == FLUSH_LAST) begin
            cnt_r <= 5'd0;
            if (!rom_stage_r) begin
              state_r     <= ST_S1_START;
              rom_start_r <= 1'b1;
              rom_stage_r <= 1'b1;
              rd_bank_r   <= BANK_MID;
            end else begin
              state_r     <= ST_UNLOAD;
              rom_stage_r <= 1'b0;
              rd_bank_r   <= BANK_IN;
              rd_addr_r   <= '0;
              out_r       <= '0;
              out_valid_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_nxt_s;
          end
        end
        ST_UNLOAD: begin
          if (out_acc_s) begin
            if (out_r == BEAT_LAST) begin
              state_r     <= ST_IDLE;
              out_r       <= '0;
              rd_addr_r   <= '0;
              out_valid_r <= 1'b0;
              in_ready_r  <= 1'b1;
              busy_r      <= 1'b0;
              frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
              out_r     <= out_r + ONE_A;
              rd_addr_r <= out_r + ONE_A;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY    = in_ready_r;
  assign OUT_VALID   = out_valid_r;
  assign ROM_START   = rom_start_r;
  assign ROM_STAGE   = rom_stage_r;
  assign BF_EN       = bf_en_r;
  assign PHASE       = phase_r;
  assign BUF_RD_ADDR = rd_addr_r;
  assign BUF_RD_BANK = rd_bank_r;
  assign BUSY        = busy_r;
  assign FRAME_CNT   = frame_cnt_r;
  assign DONE        = out_acc_s & (out_r == BEAT_LAST);

endmodule

// File: tb/tb_fft32_seq.sv
// Directed self-checking bench for the FFT sequencer.
module tb_fft32_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SOFT_CLR = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       OUT_READY = 1'b1;
  logic       IN_READY, OUT_VALID, ROM_START, ROM_STAGE, BF_EN;
  logic [1:0] PHASE;
  logic [2:0] BUF_RD_ADDR, BUF_WR_ADDR;
  logic       BUF_RD_BANK, BUF_WE, BUF_WR_BANK, BUSY, DONE;
  logic [7:0] FRAME_CNT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_frames = 8'd0;

  typedef struct {
    int         cyc;
    logic       bank;
    logic [2:0] addr;
  } ev_t;

  ev_t wr_q[$];
  ev_t rom_q[$];
  ev_t out_q[$];
  int  done_q[$];

  fft32_seq dut (
    .CLK(CLK), .RST(RST), .SOFT_CLR(SOFT_CLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ROM_START(ROM_START), .ROM_STAGE(ROM_STAGE),
    .BF_EN(BF_EN), .PHASE(PHASE), .BUF_RD_ADDR(BUF_RD_ADDR), .BUF_RD_BANK(BUF_RD_BANK),
    .BUF_WE(BUF_WE), .BUF_WR_ADDR(BUF_WR_ADDR), .BUF_WR_BANK(BUF_WR_BANK), .BUSY(BUSY),
    .DONE(DONE), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Event log sampled mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    if (BUF_WE) wr_q.push_back('{cyc, BUF_WR_BANK, BUF_WR_ADDR});
    if (ROM_START) rom_q.push_back('{cyc, ROM_STAGE, 3'd0});
    if (OUT_VALID && OUT_READY) out_q.push_back('{cyc, BUF_RD_BANK, BUF_RD_ADDR});
    if (DONE) done_q.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_log();
    wr_q.delete();
    rom_q.delete();
    out_q.delete();
    done_q.delete();
  endtask

  task automatic send_frame(input bit gaps, input bit hold);
    int sent = 0;
    bit tog = 1'b1;
    for (int g = 0; g < 64 && sent < 8; g++) begin
      IN_VALID = gaps ? tog : 1'b1;
      @(negedge CLK);
      if (IN_VALID && IN_READY) sent++;
      @(posedge CLK);
      #1;
      tog = ~tog;
    end
    IN_VALID = hold;
  endtask

  task automatic wait_done(input int limit, output bit found);
    found = 1'b0;
    for (int k = 0; k < limit && !found; k++) begin
      @(negedge CLK);
      if (DONE) found = 1'b1;
      else begin
        @(posedge CLK);
        #1;
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] obs;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    obs = {IN_READY, OUT_VALID, ROM_START, ROM_STAGE, BF_EN, PHASE, BUF_RD_ADDR, BUF_RD_BANK,
           BUF_WE, BUF_WR_ADDR, BUF_WR_BANK, BUSY, DONE, FRAME_CNT};
    checks++;
    if (obs !== {1'b1, 25'd0}) begin errors++; $display("FAIL reset_outputs got=%0h want=%0h", obs, {1'b1, 25'd0}); end
    @(negedge CLK);
    RST = 1'b1;
    tick();
    checks++;
    if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL reset_release got=%0b%0b want=10", IN_READY, BUSY); end
    send_frame(1'b0, 1'b0);
    repeat (20) tick();
    checks++;
    if (BF_EN !== 1'b1 || ROM_STAGE !== 1'b0) begin errors++; $display("FAIL reset_prerun got=%0b%0b want=10", BF_EN, ROM_STAGE); end
    #2;
    RST = 1'b0;
    #1;
    obs = {IN_READY, OUT_VALID, ROM_START, ROM_STAGE, BF_EN, PHASE, BUF_RD_ADDR, BUF_RD_BANK,
           BUF_WE, BUF_WR_ADDR, BUF_WR_BANK, BUSY, DONE, FRAME_CNT};
    checks++;
    if (obs !== {1'b1, 25'd0}) begin errors++; $display("FAIL reset_midrun got=%0h want=%0h", obs, {1'b1, 25'd0}); end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    checks++;
    if (IN_READY !== 1'b1 || BUSY !== 1'b0 || FRAME_CNT !== 8'd0 || BF_EN !== 1'b0) begin
      errors++; $display("FAIL reset_after got=%0b%0b%0h%0b want=1000", IN_READY, BUSY, FRAME_CNT, BF_EN);
    end
  endtask

  task automatic test_frame(input bit gaps, input bit hold, input string name);
    int n;
    int step;
    bit found;
    step = gaps ? 2 : 1;
    clr_log();
    OUT_READY = 1'b1;
    send_frame(gaps, hold);
    wait_done(300, found);
    tick();
    exp_frames = exp_frames + 8'd1;
    checks++;
    if (!found) begin errors++; $display("FAIL %s_done_seen got=0 want=1", name); end
    checks++;
    if (wr_q.size() != 24) begin errors++; $display("FAIL %s_wr_count got=%0d want=24", name, wr_q.size()); end
    if (wr_q.size() == 24) begin
      n = wr_q[7].cyc;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wr_q[i].cyc != n - step * (7 - i) || wr_q[i].bank !== 1'b0 || wr_q[i].addr !== 3'(i)) begin
          errors++; $display("FAIL %s_load%0d got=%0d/%0b/%0d want=%0d/0/%0d", name, i,
                             wr_q[i].cyc - n, wr_q[i].bank, wr_q[i].addr, -step * (7 - i), i);
        end
        checks++;
        if (wr_q[8+i].cyc != n + 10 + 4 * i || wr_q[8+i].bank !== 1'b1 || wr_q[8+i].addr !== 3'(i)) begin
          errors++; $display("FAIL %s_s0wr%0d got=%0d/%0b/%0d want=%0d/1/%0d", name, i,
                             wr_q[8+i].cyc - n, wr_q[8+i].bank, wr_q[8+i].addr, 10 + 4 * i, i);
        end
        checks++;
        if (wr_q[16+i].cyc != n + 48 + 4 * i || wr_q[16+i].bank !== 1'b0 || wr_q[16+i].addr !== 3'(i)) begin
          errors++; $display("FAIL %s_s1wr%0d got=%0d/%0b/%0d want=%0d/0/%0d", name, i,
                             wr_q[16+i].cyc - n, wr_q[16+i].bank, wr_q[16+i].addr, 48 + 4 * i, i);
        end
      end
      checks++;
      if (rom_q.size() != 2 || rom_q[0].cyc != n + 1 || rom_q[0].bank !== 1'b0 ||
          rom_q[1].cyc != n + 39 || rom_q[1].bank !== 1'b1) begin
        errors++; $display("FAIL %s_rom_start got=n%0d want=2 pulses at +1/+39", name, rom_q.size());
      end
      checks++;
      if (out_q.size() != 8) begin errors++; $display("FAIL %s_out_count got=%0d want=8", name, out_q.size()); end
      for (int i = 0; i < 8 && i < out_q.size(); i++) begin
        checks++;
        if (out_q[i].cyc != n + 77 + i || out_q[i].addr !== 3'(i) || out_q[i].bank !== 1'b0) begin
          errors++; $display("FAIL %s_out%0d got=%0d/%0d want=%0d/%0d", name, i,
                             out_q[i].cyc - n, out_q[i].addr, 77 + i, i);
        end
      end
      checks++;
      if (done_q.size() != 1 || done_q[0] != n + 84) begin
        errors++; $display("FAIL %s_done_cycle got=n%0d want=1 pulse at +84", name, done_q.size());
      end
    end
    checks++;
    if (FRAME_CNT !== exp_frames || IN_READY !== 1'b1 || BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL %s_end_state got=%0d/%0b%0b%0b want=%0d/100", name, FRAME_CNT,
                         IN_READY, BUSY, OUT_VALID, exp_frames);
    end
  endtask

  task automatic test_backpressure();
    int stalls = 0;
    int accepts = 0;
    int valid_cyc = 0;
    int n = 0;
    bit done_seen = 1'b0;
    clr_log();
    send_frame(1'b0, 1'b0);
    if (wr_q.size() > 0) n = wr_q[wr_q.size()-1].cyc;
    for (int g = 0; g < 300 && !done_seen; g++) begin
      if (OUT_VALID && BUF_RD_ADDR == 3'd3 && stalls < 5) begin
        OUT_READY = 1'b0;
        stalls++;
      end else begin
        OUT_READY = 1'b1;
      end
      @(negedge CLK);
      if (OUT_VALID) valid_cyc++;
      if (OUT_VALID && !OUT_READY) begin
        checks++;
        if (BUF_RD_ADDR !== 3'd3) begin errors++; $display("FAIL bp_hold_addr got=%0d want=3", BUF_RD_ADDR); end
      end
      if (OUT_VALID && OUT_READY) accepts++;
      if (DONE) begin
        done_seen = 1'b1;
        checks++;
        if (BUF_RD_ADDR !== 3'd7 || accepts != 8) begin
          errors++; $display("FAIL bp_done_beat got=%0d/%0d want=7/8", BUF_RD_ADDR, accepts);
        end
      end
      @(posedge CLK);
      #1;
    end
    OUT_READY = 1'b1;
    exp_frames = exp_frames + 8'd1;
    checks++;
    if (!done_seen || stalls != 5 || accepts != 8) begin
      errors++; $display("FAIL bp_counts got=%0b/%0d/%0d want=1/5/8", done_seen, stalls, accepts);
    end
    checks++;
    if (valid_cyc != 13) begin errors++; $display("FAIL bp_valid_held got=%0d want=13", valid_cyc); end
    checks++;
    if (out_q.size() != 8 || done_q.size() != 1) begin
      errors++; $display("FAIL bp_log got=%0d/%0d want=8/1", out_q.size(), done_q.size());
    end else begin
      checks++;
      if (out_q[0].cyc != n + 77 || out_q[3].cyc != n + 85 || out_q[7].cyc != n + 89 || done_q[0] != n + 89) begin
        errors++; $display("FAIL bp_timing got=%0d/%0d/%0d want=77/85/89",
                           out_q[0].cyc - n, out_q[3].cyc - n, out_q[7].cyc - n);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_q[i].addr !== 3'(i)) begin errors++; $display("FAIL bp_order%0d got=%0d want=%0d", i, out_q[i].addr, i); end
      end
    end
    checks++;
    if (FRAME_CNT !== exp_frames) begin errors++; $display("FAIL bp_frame_cnt got=%0d want=%0d", FRAME_CNT, exp_frames); end
  endtask

  task automatic test_abort();
    bit bad = 1'b0;
    clr_log();
    send_frame(1'b0, 1'b0);
    repeat (51) tick();
    checks++;
    if (BF_EN !== 1'b1 || ROM_STAGE !== 1'b1 || BUF_RD_BANK !== 1'b1 || PHASE !== 2'd2 || BUF_RD_ADDR !== 3'd2) begin
      errors++; $display("FAIL abort_run_pos got=%0b%0b%0b/%0d/%0d want=111/2/2", BF_EN, ROM_STAGE,
                         BUF_RD_BANK, PHASE, BUF_RD_ADDR);
    end
    SOFT_CLR = 1'b1;
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b0) begin errors++; $display("FAIL abort_done_in got=%0b want=0", DONE); end
    @(posedge CLK);
    #1;
    SOFT_CLR = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BUSY, IN_READY, BF_EN, BUF_WE, OUT_VALID, ROM_STAGE, DONE} !== 7'b0100000) begin
      errors++; $display("FAIL abort_next got=%b want=0100000",
                         {BUSY, IN_READY, BF_EN, BUF_WE, OUT_VALID, ROM_STAGE, DONE});
    end
    @(posedge CLK);
    #1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (BUF_WE || BF_EN || DONE || BUSY) bad = 1'b1;
      @(posedge CLK);
      #1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL abort_quiet got=1 want=0"); end
    checks++;
    if (FRAME_CNT !== exp_frames || done_q.size() != 0) begin
      errors++; $display("FAIL abort_count got=%0d/%0d want=%0d/0", FRAME_CNT, done_q.size(), exp_frames);
    end
  endtask

  task automatic test_clear_in_idle();
    clr_log();
    IN_VALID = 1'b1;
    SOFT_CLR = 1'b1;
    @(negedge CLK);
    checks++;
    if (BUF_WE !== 1'b0) begin errors++; $display("FAIL clr_idle_we got=%0b want=0", BUF_WE); end
    @(posedge CLK);
    #1;
    SOFT_CLR = 1'b0;
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL clr_idle_busy got=%0b want=0", BUSY); end
    repeat (3) tick();
    IN_VALID = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || wr_q.size() != 3) begin
      errors++; $display("FAIL clr_partial got=%0b/%0d want=1/3", BUSY, wr_q.size());
    end
    SOFT_CLR = 1'b1;
    tick();
    SOFT_CLR = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || IN_READY !== 1'b1) begin
      errors++; $display("FAIL clr_partial_idle got=%0b%0b want=01", BUSY, IN_READY);
    end
    test_frame(1'b0, 1'b0, "post_clear");
  endtask

  task automatic test_wrap();
    bit found;
    while (exp_frames != 8'd255) begin
      clr_log();
      send_frame(1'b0, 1'b0);
      wait_done(200, found);
      tick();
      exp_frames = exp_frames + 8'd1;
      checks++;
      if (!found) begin errors++; $display("FAIL wrap_done got=0 want=1"); end
    end
    checks++;
    if (FRAME_CNT !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d want=255", FRAME_CNT); end
    test_frame(1'b0, 1'b0, "wrap");
    checks++;
    if (FRAME_CNT !== 8'd0) begin errors++; $display("FAIL wrap_zero got=%0d want=0", FRAME_CNT); end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0, 1'b0, "single");
    test_frame(1'b1, 1'b0, "gaps");
    test_backpressure();
    test_abort();
    test_frame(1'b0, 1'b0, "post_abort");
    test_clear_in_idle();
    test_frame(1'b0, 1'b1, "busy_ignore");
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
